serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
- Parallel-to-serial frame transmitter: the send-side counterpart of the team's clocked storage/capture primitives.
- Accepts a WIDTH-bit word over a valid/ready handshake. Drives it onto a single-bit line as start bit, data LSB first, optional even parity, then stop bit.
- Sits between a word producer and a serial link whose receiver samples one bit per clk.

Parameters:
- WIDTH, 8, data word width in bits (≥1).
- PARITY, 1, 1 = append even-parity bit after data; 0 = no parity bit.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  word to transmit; sampled only on an accepted handshake.
- load_valid  input  1  producer has a word on din.
- load_ready  output  1  transmitter can accept a word this cycle.
- sdo  output  1  serial line; idle level 1.
- busy  output  1  frame in progress (START through STOP).
- done  output  1  one-cycle pulse during the STOP bit cycle.

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous and active-high.
  - Reset outcome (cycle after rst sampled high):
    - state=IDLE
    - sdo=1
    - busy=0
    - done=0
    - shift register and bit counter cleared
  - load_ready=0 while rst is high; load_ready=1 in the first cycle after reset.
- Output registration: sdo, busy and done are registered. load_ready is combinational from state and rst.
- States: IDLE, START, DATA, PARITY, STOP.
- Handshake:
  - Accept = load_valid && load_ready at a rising edge.
  - load_ready=1 in IDLE and in STOP, else 0.
  - din is captured into the shift register on accept.
  - din/load_valid are ignored when not ready.
- Transitions:
  - IDLE -> START on accept.
  - START -> DATA after 1 cycle.
  - DATA stays WIDTH cycles, shifting right, sdo = shreg[0].
  - DATA -> PARITY if PARITY=1, else DATA -> STOP.
  - PARITY -> STOP after 1 cycle.
  - STOP -> START if accept in STOP (back-to-back, no idle gap), else STOP -> IDLE.
- Line levels per state:
  - IDLE: sdo=1.
  - START: sdo=0.
  - DATA: sdo = data bit.
  - PARITY: sdo = XOR of all WIDTH captured bits (even parity: total ones in data+parity is even).
  - STOP: sdo=1.
- Latency and frame length:
  - Accept at edge T → start bit visible in cycle T+1.
  - Data bit i visible in cycle T+2+i.
  - Frame length = WIDTH+2+PARITY cycles.
- Status flags:
  - busy=1 exactly in START, DATA, PARITY, STOP cycles.
  - done=1 only in STOP cycles.
- Parity: computed from the captured word at accept time, not from the shifting register.
- Bit counter: width clog2(WIDTH)+1; counts 0..WIDTH-1 in DATA, wrap is not used.
- Reset mid-frame: frame is aborted and the line returns to 1 next cycle. No done pulse. A partially sent word is lost.
- Simultaneous rst and accept: rst wins; the word is not captured.
- din changing after accept has no effect on the current frame.

Test Plan:
- Reset: rst=1 for 2 cycles then 0, load_valid=0 → sdo=1, busy=0, done=0, load_ready=1 held for 10 cycles.
- Single frame (WIDTH=8, PARITY=1), din=0xA5 accepted at T:
  - sdo cycles T+1..T+11 = 0,1,0,1,0,0,1,0,1,0,1.
  - busy=1 for those 11 cycles; done=1 only at T+11; load_ready=0 T+1..T+10.
- Odd parity source: din=0x07 → parity bit = 1. din=0x00 → data all 0, parity 0, stop 1.
- Back-to-back: load_valid held high with 0xA5 then 0x3C (accepted during STOP) → second start bit immediately after first stop bit. Total 22 busy cycles, no idle cycle, two done pulses.
- PARITY=0 build, din=0xFF → frame 0,1×8,1 (10 cycles), done in cycle 10.
- Mid-frame reset: assert rst during data bit 3 of 0xA5 → sdo=1, busy=0, done=0 next cycle. A following accept of 0x5A transmits a correct full frame.

Source files
------------

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel word to start/LSB-first data/optional even parity/stop serial frame
module serial_frame_tx #(
    parameter int WIDTH  = 8,
    parameter int PARITY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sdo,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_shreg, w_shreg;
    logic [CW-1:0]    r_cnt;
    logic             r_par, r_sdo, r_busy, r_done, w_accept, w_sdo;
    assign load_ready = !rst && (r_state == S_IDLE || r_state == S_STOP);
    assign w_accept   = load_valid && load_ready;
    assign w_shreg    = w_accept ? din : (r_state == S_DATA ? r_shreg >> 1 : r_shreg);
    assign sdo        = r_sdo;
    assign busy       = r_busy;
    assign done       = r_done;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = w_accept ? S_START : S_IDLE;
            S_START:  w_next = S_DATA;
            S_DATA:   w_next = (r_cnt != CW'(WIDTH - 1)) ? S_DATA : (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: w_next = S_STOP;
            S_STOP:   w_next = w_accept ? S_START : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        w_sdo = (w_next == S_START)  ? 1'b0 :
                (w_next == S_DATA)   ? w_shreg[0] :
                (w_next == S_PARITY) ? r_par : 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_par   <= 1'b0;
            r_sdo   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_shreg <= w_shreg;
            r_cnt   <= (r_state == S_DATA) ? r_cnt + CW'(1) : '0;
            r_par   <= w_accept ? ^din : r_par;
            r_sdo   <= w_sdo;
            r_busy  <= w_next != S_IDLE;
            r_done  <= w_next == S_STOP;
        end
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: checks a parity and a no-parity build against a queue-of-frame-bits model
module tb_serial_frame_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din0 = '0, din1 = '0;
    logic       lv0 = 1'b0, lv1 = 1'b0;
    logic       rdy0, rdy1, sdo0, sdo1, busy0, busy1, done0, done1;
    logic [1:0] q0[$], q1[$];
    int         n_cmp = 0, n_bad = 0;
    always #5 clk = ~clk;
    serial_frame_tx #(.WIDTH(8), .PARITY(1)) u_par (
        .clk(clk), .rst(rst), .din(din0), .load_valid(lv0),
        .load_ready(rdy0), .sdo(sdo0), .busy(busy0), .done(done0)
    );
    serial_frame_tx #(.WIDTH(8), .PARITY(0)) u_nopar (
        .clk(clk), .rst(rst), .din(din1), .load_valid(lv1),
        .load_ready(rdy1), .sdo(sdo1), .busy(busy1), .done(done1)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask
    // Each queue holds {sdo, done} for the current and upcoming cycles; the last entry is the stop bit.
    task automatic step(input logic r, input logic v0, input logic [7:0] d0,
                        input logic v1, input logic [7:0] d1);
        logic a0, a1;
        rst = r; lv0 = v0; din0 = d0; lv1 = v1; din1 = d1;
        #1;
        chk("ready_p", rdy0, !r && q0.size() <= 1);
        chk("ready_n", rdy1, !r && q1.size() <= 1);
        a0 = v0 && !r && q0.size() <= 1;
        a1 = v1 && !r && q1.size() <= 1;
        @(posedge clk);
        if (r) begin
            q0.delete();
            q1.delete();
        end else begin
            if (q0.size() != 0) void'(q0.pop_front());
            if (q1.size() != 0) void'(q1.pop_front());
            if (a0) begin
                q0.push_back(2'b00);
                for (int i = 0; i < 8; i++) q0.push_back({d0[i], 1'b0});
                q0.push_back({^d0, 1'b0});
                q0.push_back(2'b11);
            end
            if (a1) begin
                q1.push_back(2'b00);
                for (int i = 0; i < 8; i++) q1.push_back({d1[i], 1'b0});
                q1.push_back(2'b11);
            end
        end
        #1;
        chk("sdo_p",  sdo0,  q0.size() != 0 ? q0[0][1] : 1'b1);
        chk("busy_p", busy0, q0.size() != 0);
        chk("done_p", done0, q0.size() != 0 ? q0[0][0] : 1'b0);
        chk("sdo_n",  sdo1,  q1.size() != 0 ? q1[0][1] : 1'b1);
        chk("busy_n", busy1, q1.size() != 0);
        chk("done_n", done1, q1.size() != 0 ? q1[0][0] : 1'b0);
        @(negedge clk);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom), 1'b0, 8'($urandom));
    endtask
    initial begin
        step(1'b1, 1'b1, 8'hA5, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 8'hA5, 1'b1, 8'hFF);
        idle(10);
        step(1'b0, 1'b1, 8'hA5, 1'b1, 8'hFF);
        idle(13);
        step(1'b0, 1'b1, 8'h07, 1'b1, 8'h00);
        idle(13);
        step(1'b0, 1'b1, 8'h00, 1'b1, 8'h81);
        idle(13);
        for (int k = 0; k < 12; k++)
            step(1'b0, 1'b1, k == 0 ? 8'hA5 : 8'h3C, 1'b1, k == 0 ? 8'hFF : 8'h3C);
        idle(14);
        step(1'b0, 1'b1, 8'hA5, 1'b1, 8'hA5);
        idle(4);
        step(1'b1, 1'b1, 8'h11, 1'b1, 8'h22);
        step(1'b0, 1'b1, 8'h5A, 1'b1, 8'h5A);
        idle(13);
        for (int k = 0; k < 1500; k++)
            step($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, 8'($urandom),
                 $urandom_range(0, 3) == 0, 8'($urandom));
        idle(14);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
